// File: rtl/gearbox_stim_pkg.sv
// Shared definitions for the gearbox stimulus generator: mode encodings,
// FSM state type and LFSR constants. The PRBS feature is enabled by
// defining GEARBOX_STIM_PRBS_EN.
package gearbox_stim_pkg;

    localparam logic [1:0] MODE_INCR  = 2'd0;
    localparam logic [1:0] MODE_PRBS  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    localparam int               LFSR_LEN      = 31;
    localparam int               LFSR_TAP      = 28;
    localparam logic [LFSR_LEN-1:0] LFSR_ZERO_SUB = 31'h7FFF_FFFF;

    // Collapses the raw mode input to the three behaviours the datapath knows.
    // Code 3, and PRBS when the LFSR is not built, both fall back to INCR.
    function automatic logic [1:0] eff_mode(input logic [1:0] m, input logic prbs_en);
        logic [1:0] r;
        r = MODE_INCR;
        if (m == MODE_CONST)
            r = MODE_CONST;
        else if (m == MODE_PRBS && prbs_en)
            r = MODE_PRBS;
        return r;
    endfunction

endpackage

// File: rtl/gearbox_stim_gen_lfsr.sv
// Parallel PRBS31 (x^31 + x^28 + 1) word generator. Each load or advance
// steps the LFSR DATA_W times; the first bit produced lands in the word MSB.
// o_word is the word generated from the seed (during load) or from the
// current state, so the parent registers it on the same edge.
// Built only when GEARBOX_STIM_PRBS_EN is defined.
module gearbox_stim_lfsr
    import gearbox_stim_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk_200m,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [DATA_W-1:0] i_seed,
    output logic [DATA_W-1:0] o_word
);

    logic [LFSR_LEN-1:0] r_state;
    logic [LFSR_LEN-1:0] w_seed31;
    logic [LFSR_LEN-1:0] w_src;
    logic [LFSR_LEN-1:0] w_nxt;
    logic [DATA_W-1:0]   w_word;

    generate
        if (DATA_W >= LFSR_LEN) begin : g_trunc
            assign w_seed31 = i_seed[LFSR_LEN-1:0];
        end else begin : g_ext
            assign w_seed31 = {{(LFSR_LEN-DATA_W){1'b0}}, i_seed};
        end
    endgenerate

    // Unroll DATA_W Fibonacci steps from either the fresh seed or the held state.
    always_comb begin
        w_src  = i_load ? ((w_seed31 == '0) ? LFSR_ZERO_SUB : w_seed31) : r_state;
        w_nxt  = w_src;
        w_word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_word[DATA_W-1-i] = w_nxt[LFSR_LEN-1] ^ w_nxt[LFSR_TAP-1];
            w_nxt              = {w_nxt[LFSR_LEN-2:0], w_word[DATA_W-1-i]};
        end
    end

    // LFSR state moves only when a word is consumed.
    always_ff @(posedge clk_200m or posedge reset) begin
        if (reset)
            r_state <= '0;
        else if (i_load || i_advance)
            r_state <= w_nxt;
    end

    assign o_word = w_word;

endmodule

// File: rtl/gearbox_stim_gen.sv
// Framed multi-channel stimulus source on a valid/ready stream.
// Data patterns: INCR (per-channel add, no inter-channel carry), CONST, and
// PRBS31 when GEARBOX_STIM_PRBS_EN is defined (otherwise PRBS acts as INCR).
// A programmable on/off duty pattern gaps the stream; data_last marks the
// final beat and done pulses once after it transfers.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for start with non-zero frame_len
//   ST_ON   | presenting beats, valid high, transfer on data_ready
//   ST_OFF  | burst gap, valid low for off_len cycles
module gearbox_stim_gen
    import gearbox_stim_pkg::*;
#(
    parameter  int CH_NUM = 3,
    parameter  int CH_W   = 8,
    parameter  int LEN_W  = 16,
    parameter  int GAP_W  = 8,
    localparam int DATA_W = CH_NUM * CH_W
) (
    input  logic              clk_200m,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [GAP_W-1:0]  on_len,
    input  logic [GAP_W-1:0]  off_len,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [CH_W-1:0]   step,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data,
    output logic              data_last,
    output logic              busy,
    output logic              done
);

`ifdef GEARBOX_STIM_PRBS_EN
    localparam logic PRBS_EN = 1'b1;
`else
    localparam logic PRBS_EN = 1'b0;
`endif

    state_e            r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_frame_len, w_frame_len_nxt;
    logic [GAP_W-1:0]  r_on_len, w_on_len_nxt;
    logic [GAP_W-1:0]  r_off_len, w_off_len_nxt;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [CH_W-1:0]   r_step, w_step_nxt;
    logic [LEN_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
    logic [GAP_W-1:0]  r_on_cnt, w_on_cnt_nxt;
    logic [GAP_W-1:0]  r_off_cnt, w_off_cnt_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_last, w_last_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic              w_accept;
    logic              w_xfer;
    logic              w_last_beat;
    logic [DATA_W-1:0] w_incr_word;
    logic [DATA_W-1:0] w_next_word;
    logic [DATA_W-1:0] w_first_word;

    assign w_accept    = (r_state == ST_IDLE) && start && (frame_len != '0);
    assign w_xfer      = (r_state == ST_ON) && r_valid && data_ready;
    assign w_last_beat = (r_beat_cnt == r_frame_len - LEN_W'(1));

`ifdef GEARBOX_STIM_PRBS_EN
    logic              w_lfsr_load;
    logic              w_lfsr_adv;
    logic [DATA_W-1:0] w_lfsr_word;

    assign w_lfsr_load = w_accept;
    assign w_lfsr_adv  = w_xfer && !w_last_beat && (r_mode == MODE_PRBS);

    gearbox_stim_lfsr #(
        .DATA_W (DATA_W)
    ) u_lfsr (
        .clk_200m  (clk_200m),
        .reset     (reset),
        .i_load    (w_lfsr_load),
        .i_advance (w_lfsr_adv),
        .i_seed    (seed),
        .o_word    (w_lfsr_word)
    );
`endif

    // Per-channel increment; each lane wraps on its own.
    always_comb begin
        w_incr_word = '0;
        for (int c = 0; c < CH_NUM; c++)
            w_incr_word[c*CH_W +: CH_W] = r_data[c*CH_W +: CH_W] + r_step;
    end

    // Select the word that follows the current one, and the first word of a frame.
    always_comb begin
        w_next_word  = w_incr_word;
        w_first_word = seed;
        if (r_mode == MODE_CONST)
            w_next_word = r_data;
`ifdef GEARBOX_STIM_PRBS_EN
        else if (r_mode == MODE_PRBS)
            w_next_word = w_lfsr_word;
        if (eff_mode(mode, PRBS_EN) == MODE_PRBS)
            w_first_word = w_lfsr_word;
`endif
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_len_nxt = r_frame_len;
        w_on_len_nxt    = r_on_len;
        w_off_len_nxt   = r_off_len;
        w_mode_nxt      = r_mode;
        w_step_nxt      = r_step;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_on_cnt_nxt    = r_on_cnt;
        w_off_cnt_nxt   = r_off_cnt;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid;
        w_last_nxt      = r_last;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                if (w_accept) begin
                    w_frame_len_nxt = frame_len;
                    w_on_len_nxt    = (on_len == '0) ? GAP_W'(1) : on_len;
                    w_off_len_nxt   = off_len;
                    w_mode_nxt      = eff_mode(mode, PRBS_EN);
                    w_step_nxt      = step;
                    w_beat_cnt_nxt  = '0;
                    w_on_cnt_nxt    = '0;
                    w_off_cnt_nxt   = '0;
                    w_data_nxt      = w_first_word;
                    w_valid_nxt     = 1'b1;
                    w_last_nxt      = (frame_len == LEN_W'(1));
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = ST_ON;
                end
            end
            ST_ON: begin
                if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
                    w_on_cnt_nxt   = r_on_cnt + GAP_W'(1);
                    if (w_last_beat) begin
                        w_valid_nxt  = 1'b0;
                        w_last_nxt   = 1'b0;
                        w_busy_nxt   = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_on_cnt_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_data_nxt = w_next_word;
                        w_last_nxt = (r_beat_cnt + LEN_W'(2) == r_frame_len);
                        if ((r_on_cnt + GAP_W'(1) == r_on_len) && (r_off_len != '0)) begin
                            w_valid_nxt   = 1'b0;
                            w_last_nxt    = 1'b0;
                            w_on_cnt_nxt  = '0;
                            w_off_cnt_nxt = r_off_len;
                            w_state_nxt   = ST_OFF;
                        end
                    end
                end
            end
            ST_OFF: begin
                w_off_cnt_nxt = r_off_cnt - GAP_W'(1);
                if (r_off_cnt == GAP_W'(1)) begin
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = w_last_beat;
                    w_state_nxt = ST_ON;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_200m or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Latched configuration, counters and registered outputs.
    always_ff @(posedge clk_200m or posedge reset) begin
        if (reset) begin
            r_frame_len <= '0;
            r_on_len    <= '0;
            r_off_len   <= '0;
            r_mode      <= MODE_INCR;
            r_step      <= '0;
            r_beat_cnt  <= '0;
            r_on_cnt    <= '0;
            r_off_cnt   <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_frame_len <= w_frame_len_nxt;
            r_on_len    <= w_on_len_nxt;
            r_off_len   <= w_off_len_nxt;
            r_mode      <= w_mode_nxt;
            r_step      <= w_step_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_on_cnt    <= w_on_cnt_nxt;
            r_off_cnt   <= w_off_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign data_valid = r_valid;
    assign data       = r_data;
    assign data_last  = r_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
